bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the FSM sequence-detector stage. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `out`, qualified by `out_valid`. Its serial output connects directly to the detector's single-bit `in` port, so whole test patterns are loaded as words rather than driven bit by bit.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to serialize; sampled only on an accept.
- `load_valid`  in  1  upstream has a word on `data_in`.
- `load_ready`  out  1  block can take a word this cycle. Combinational from state; forced to 0 while `rst`=1.
- `out`  out  1  current serial bit; registered; 0 whenever `out_valid`=0.
- `out_valid`  out  1  `out` carries a data bit this cycle; registered.
- `busy`  out  1  1 in SHIFT state or while the holding register is full.

## Operation
- Accept: `load_valid`=1 and `load_ready`=1 at a rising edge.
- State machine:
  - States are IDLE and SHIFT.
  - Registers: shift register `sh`[WIDTH-1:0] and bit counter `cnt` ($clog2(WIDTH) bits).
- IDLE:
  - `load_ready`=1.
  - On accept: `sh`<=`data_in`, `cnt`<=WIDTH-1, go to SHIFT.
- SHIFT:
  - `out_valid`=1 and `out` = head bit of `sh` (MSB or LSB per `MSB_FIRST`).
  - Each edge shifts `sh` toward the head and decrements `cnt`.
- Last bit (`cnt`=0):
  - Next edge returns to IDLE; `sh` and `cnt` are cleared.
  - The exception is a preload refill (see Configuration).
- Without preload, `load_ready`=0 throughout SHIFT, and `load_valid` is ignored there.
- `data_in` changes when no accept occurs have no effect.
- Arithmetic: `cnt` never wraps. It is reloaded only on accept or refill.

## Timing
- Reset values: `load_ready`=0 while `rst`=1 and 1 on the first cycle after; `out`=0; `out_valid`=0; `busy`=0; state IDLE; `sh`=0; `cnt`=0; holding register empty.
- Latency: first bit appears on `out` in the cycle immediately after the accept edge.
- A word occupies exactly WIDTH consecutive `out_valid` cycles.
- Throughput without preload: one word per WIDTH+1 cycles, with at least one idle cycle (`out_valid`=0) between words.
- Reset mid-word: at the next edge everything returns to reset values; the partial word is dropped, with no further bits and no resumption.
- `rst` and accept asserted together: reset wins and the word is not taken.

## Configuration
- Macro: `BIT_SERIALIZER_PRELOAD_EN`.
- When defined, the block adds a one-word holding register `hold` with a `hold_full` flag:
  - `load_ready` = !`hold_full` (and !`rst`), in any state.
  - Accept in IDLE loads `sh` directly. Accept in SHIFT loads `hold` and sets `hold_full`.
  - On the last-bit edge with `hold_full`=1: `sh`<=`hold`, `cnt`<=WIDTH-1, `hold_full`<=0, and the state stays SHIFT.
  - On the last-bit edge with `hold_full`=0 and an accept that same cycle: `sh`<=`data_in` and the state stays SHIFT.
  - Either case gives back-to-back words with zero gap cycles.
  - Reset also clears `hold_full`.
- When undefined, no holding register exists and behaviour is exactly as in Operation.

## Test plan
- Reset, then accept 8'hB5 with MSB_FIRST=1 -> `out` = 1,0,1,1,0,1,0,1 over 8 cycles with `out_valid`=1; `load_ready`=0 during the word; `out_valid`=0 on the 9th cycle.
- MSB_FIRST=0, accept 8'hB5 -> `out` = 1,0,1,0,1,1,0,1.
- Drive 8'hBB into a downstream 1011 Moore detector -> the detector output pulses once per completed 1011 pattern, at the cycles the bench predicts for the detector's overlap rule.
- Assert `rst` after the 3rd bit of 8'hFF -> the next cycle shows `out`=0, `out_valid`=0, `busy`=0, and no remaining bits are emitted.
- Hold `load_valid`=1 with 8'hA5 then 8'h3C, preload undefined -> 16 data cycles separated by exactly one `out_valid`=0 cycle.
- Same stimulus with `BIT_SERIALIZER_PRELOAD_EN` defined -> 16 contiguous `out_valid` cycles, the second word accepted into `hold` one cycle after the first, and `load_ready`=0 while `hold_full`=1.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word-load handshake and serial output bundle for bit_serializer.
// master = upstream word source / serial sink side, slave = the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             busy;

    modport master (
        output data_in, load_valid,
        input  load_ready, out, out_valid, busy
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, out, out_valid, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word out one bit per clock.
// Optional one-word preload buffer for gapless words: BIT_SERIALIZER_PRELOAD_EN.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ready;
    logic             accept;
    logic             head;

`ifdef BIT_SERIALIZER_PRELOAD_EN
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
`endif

    assign head   = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign accept = bus.load_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
`ifdef BIT_SERIALIZER_PRELOAD_EN
            hold_full <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            cnt   <= cnt_nxt;
`ifdef BIT_SERIALIZER_PRELOAD_EN
            hold_full <= hold_full_nxt;
`endif
        end
    end

`ifdef BIT_SERIALIZER_PRELOAD_EN
    // Holding word is qualified by hold_full, so its contents need no reset.
    always_ff @(posedge clk) begin
        hold <= hold_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        cnt_nxt   = cnt;
`ifdef BIT_SERIALIZER_PRELOAD_EN
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = bus.data_in;
                    cnt_nxt   = LAST;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
`ifdef BIT_SERIALIZER_PRELOAD_EN
                    // Refill from hold (or a same-cycle accept) keeps words contiguous.
                    if (hold_full) begin
                        sh_nxt        = hold;
                        cnt_nxt       = LAST;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        sh_nxt  = bus.data_in;
                        cnt_nxt = LAST;
                    end else begin
                        state_nxt = IDLE;
                        sh_nxt    = '0;
                        cnt_nxt   = '0;
                    end
`else
                    state_nxt = IDLE;
                    sh_nxt    = '0;
                    cnt_nxt   = '0;
`endif
                end else begin
                    sh_nxt  = MSB_FIRST ? (sh << 1) : (sh >> 1);
                    cnt_nxt = cnt - CW'(1);
`ifdef BIT_SERIALIZER_PRELOAD_EN
                    if (accept) begin
                        hold_nxt      = bus.data_in;
                        hold_full_nxt = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    // Outputs decode flops only; load_ready is additionally gated by rst.
    always_comb begin
`ifdef BIT_SERIALIZER_PRELOAD_EN
        ready    = !hold_full;
        bus.busy = (state == SHIFT) || hold_full;
`else
        ready    = (state == IDLE);
        bus.busy = (state == SHIFT);
`endif
        if (rst) begin
            ready = 1'b0;
        end
        bus.load_ready = ready;
        bus.out_valid  = (state == SHIFT);
        bus.out        = (state == SHIFT) ? head : 1'b0;
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first and LSB-first instances
// against a queue-based reference model, plus directed scenario checks.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       lv;

    bit_serializer_if #(.WIDTH(8)) if_m ();
    bit_serializer_if #(.WIDTH(8)) if_l ();

    assign if_m.data_in    = data;
    assign if_m.load_valid = lv;
    assign if_l.data_in    = data;
    assign if_l.load_valid = lv;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_m));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: pending serial bits per bit order, plus optional held word.
    bit         qm[$];
    bit         ql[$];
    logic [7:0] hw;
    bit         hf;
    bit         acc;
    logic       s_ov, s_out, s_outl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) qm.push_back(w[i]);
        for (int i = 0; i < 8; i++) ql.push_back(w[i]);
    endfunction

    task automatic cycle();
        logic e_ov, e_om, e_ol, e_lr, e_busy;
        @(negedge clk);
        e_ov   = (qm.size() > 0);
        e_om   = e_ov ? qm[0] : 1'b0;
        e_ol   = e_ov ? ql[0] : 1'b0;
        e_lr   = !rst && (PRE ? !hf : (qm.size() == 0));
        e_busy = e_ov || hf;
        chk("m_out_valid", 32'(if_m.out_valid), 32'(e_ov));
        chk("m_out", 32'(if_m.out), 32'(e_om));
        chk("m_load_ready", 32'(if_m.load_ready), 32'(e_lr));
        chk("m_busy", 32'(if_m.busy), 32'(e_busy));
        chk("l_out_valid", 32'(if_l.out_valid), 32'(e_ov));
        chk("l_out", 32'(if_l.out), 32'(e_ol));
        chk("l_load_ready", 32'(if_l.load_ready), 32'(e_lr));
        s_ov   = if_m.out_valid;
        s_out  = if_m.out;
        s_outl = if_l.out;
        acc    = lv && e_lr;
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
            hf = 1'b0;
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (qm.size() == 0) begin
                if (hf) begin
                    push_word(hw);
                    hf = 1'b0;
                end else if (acc) begin
                    push_word(data);
                end
            end else if (acc) begin
                hw = data;
                hf = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        logic [7:0]  capm, capl;
        logic [11:0] det_hist;
        logic [3:0]  win;
        logic        det_q;
        logic [22:0] vrec, vexp;
        int          nbits, nacc, first_k, second_k;
        bit          started;

        rst = 1'b1; lv = 1'b0; data = 8'h00; hf = 1'b0; hw = 8'h00;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();

        // MSB-first and LSB-first order of 8'hB5
        data = 8'hB5; lv = 1'b1;
        cycle();
        chk("b5_accept", 32'(acc), 32'd1);
        lv = 1'b0; data = 8'h00;
        capm = '0; capl = '0; nbits = 0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (s_ov) begin
                capm = {capm[6:0], s_out};
                capl = {capl[6:0], s_outl};
                nbits++;
            end
        end
        chk("b5_msb_stream", 32'(capm), 32'hB5);
        chk("b5_lsb_stream", 32'(capl), 32'hAD);
        chk("b5_bit_count", 32'(nbits), 32'd8);
        chk("b5_gap_after", 32'(s_ov), 32'd0);

        // 8'hBB into a 1011 Moore detector: pulses one cycle after bits 4 and 8
        cycle();
        data = 8'hBB; lv = 1'b1;
        cycle();
        lv = 1'b0;
        win = '0; det_q = 1'b0; det_hist = '0;
        for (int i = 1; i < 12; i++) begin
            cycle();
            det_hist[i] = det_q;
            if (s_ov) win = {win[2:0], s_out};
            det_q = s_ov && (win == 4'b1011);
        end
        chk("det_1011_pulses", 32'(det_hist), 32'h220);

        // Reset after the 3rd bit of 8'hFF drops the rest of the word
        data = 8'hFF; lv = 1'b1;
        cycle();
        lv = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_mid_out_valid", 32'(s_ov), 32'd0);
        chk("rst_mid_out", 32'(s_out), 32'd0);
        nbits = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_ov) nbits++;
        end
        chk("rst_mid_no_resume", 32'(nbits), 32'd0);

        // Reset together with a valid word: the word is not taken
        rst = 1'b1; lv = 1'b1; data = 8'h55;
        cycle();
        chk("rst_accept_blocked", 32'(acc), 32'd0);
        rst = 1'b0; lv = 1'b0;
        cycle();
        chk("rst_accept_idle", 32'(s_ov), 32'd0);
        cycle();

        // Two words 8'hA5, 8'h3C with load_valid held high
        data = 8'hA5; lv = 1'b1;
        nacc = 0; started = 1'b0; vrec = '0; first_k = -1; second_k = -1;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (started) vrec = {vrec[21:0], s_ov};
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    started = 1'b1;
                    first_k = k;
                    data = 8'h3C;
                end else if (nacc == 2) begin
                    second_k = k;
                    lv = 1'b0;
                end
            end
        end
        lv = 1'b0;
        vexp = PRE ? {{16{1'b1}}, 7'b0} : {{8{1'b1}}, 1'b0, {8{1'b1}}, 6'b0};
        chk("two_word_accepts", 32'(nacc), 32'd2);
        chk("two_word_valid_pattern", 32'(vrec), 32'(vexp));
        chk("two_word_accept_spacing", 32'(second_k - first_k), PRE ? 32'd1 : 32'd9);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            lv   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            cycle();
        end
        rst = 1'b0; lv = 1'b0;
        for (int k = 0; k < 12; k++) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
